// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction-fetch path: FSM states, the end-of-program
// marker and the prefetch-buffer entry layout.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [31:0] END_WORD   = 32'h0000_0000;
  localparam logic [1:0]  FIFO_DEPTH = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetch entries with push, pop and flush.
// Flush wins over push/pop; push while full is accepted only with a pop.
module fetch_fifo
  import fetch_sequencer_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t r_mem [FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != FIFO_DEPTH) || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FIFO_DEPTH);
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads the combinational ROM and
// feeds decode through a 2-entry prefetch buffer; redirects flush and reload.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  input  logic              i_redirect_valid,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_instr_pc,
  output logic              o_halted,
  output logic              o_error,
  output state_t            o_dbg_state,
  output logic [1:0]        o_dbg_count
);

  // Handshake: the head entry transfers on any edge where o_instr_valid and
  // i_instr_ready are both high; the head stays stable until then or a flush.

  state_t       r_state;
  logic [31:0]  r_pc;
  logic         r_error;

  state_t       w_state_nxt;
  logic [31:0]  w_pc_nxt;
  logic         w_push;
  logic         w_err_set;
  logic         w_pop;
  logic         w_space;
  logic         w_pc_bad;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_data;

  assign w_pop       = o_instr_valid && i_instr_ready;
  assign w_space     = !w_full || w_pop;
  assign w_pc_bad    = (r_pc[31:ADDR_W+2] != '0) || (r_pc[1:0] != 2'b00);
  assign w_push_data = '{instr: i_rom_data, pc: r_pc};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_err_set   = 1'b0;
    if (i_redirect_valid) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = i_redirect_pc;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_space) begin
            // A bad PC makes rom_data meaningless, so it is checked first.
            if (w_pc_bad) begin
              w_state_nxt = ST_ERR;
              w_err_set   = 1'b1;
            end else if (i_rom_data == END_WORD) begin
              w_state_nxt = ST_HALT;
            end else begin
              w_push   = 1'b1;
              w_pc_nxt = r_pc + 32'd4;
            end
          end
        end
        ST_HALT: w_state_nxt = ST_HALT;
        ST_ERR:  w_state_nxt = ST_ERR;
        default: w_state_nxt = ST_ERR;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_error <= r_error | w_err_set;
    end
  end

  fetch_fifo u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop && !i_redirect_valid),
    .i_flush     (i_redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign o_rom_addr    = r_pc[ADDR_W+1:2];
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_head.instr;
  assign o_instr_pc    = w_head.pc;
  assign o_halted      = (r_state == ST_HALT);
  assign o_error       = r_error;
  assign o_dbg_state   = r_state;
  assign o_dbg_count   = w_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, streaming, backpressure,
// redirect flush, halt on end word, error on bad PC, reset over redirect.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic        error;
  state_t      dbg_state;
  logic [1:0]  dbg_count;

  logic [31:0] rom [32];
  logic [31:0] exp_q [$];
  int          n_total;
  int          n_bad;

  fetch_sequencer #(.ADDR_W(5), .RESET_PC(32'h0)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .o_rom_addr       (rom_addr),
    .i_rom_data       (rom_data),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_instr_valid    (instr_valid),
    .i_instr_ready    (instr_ready),
    .o_instr          (instr),
    .o_instr_pc       (instr_pc),
    .o_halted         (halted),
    .o_error          (error),
    .o_dbg_state      (dbg_state),
    .o_dbg_count      (dbg_count)
  );

  assign rom_data = rom[rom_addr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0013 | (i << 7);
    rom[0]  = 32'h0030_0413;
    rom[1]  = 32'h0010_0493;
    rom[2]  = 32'h0100_0913;
    rom[13] = 32'h0062_8863;
    rom[29] = 32'h0080_2383;
    rom[30] = 32'h0000_0000;

    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    repeat (3) step();

    // reset state
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(ST_RUN));

    // streaming with ready held high
    reset       = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("s0_valid", 32'(instr_valid), 32'd1);
    chk("s0_instr", instr, 32'h0030_0413);
    chk("s0_pc", instr_pc, 32'h0);
    step();
    chk("s1_valid", 32'(instr_valid), 32'd1);
    chk("s1_instr", instr, 32'h0010_0493);
    chk("s1_pc", instr_pc, 32'h4);
    step();
    chk("s2_valid", 32'(instr_valid), 32'd1);
    chk("s2_instr", instr, 32'h0100_0913);
    chk("s2_pc", instr_pc, 32'h8);
    chk("s2_rom_addr", 32'(rom_addr), 32'd3);

    // backpressure: buffer fills, pc freezes at 8
    reset = 1'b0;
    step();
    reset       = 1'b1;
    instr_ready = 1'b0;
    repeat (5) step();
    chk("bp_rom_addr", 32'(rom_addr), 32'd2);
    chk("bp_count", 32'(dbg_count), 32'd2);
    chk("bp_head", instr, 32'h0030_0413);
    chk("bp_head_pc", instr_pc, 32'h0);
    for (int i = 0; i < 4; i++) exp_q.push_back(rom[i]);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_valid", 32'(instr_valid), 32'd1);
      chk("bp_drain_instr", instr, exp_q.pop_front());
      chk("bp_drain_pc", instr_pc, 32'(4 * i));
      step();
    end

    // redirect with a full buffer: one bubble, flushed entries never seen
    instr_ready = 1'b0;
    step();
    chk("rd_pre_count", 32'(dbg_count), 32'd2);
    chk("rd_pre_head", instr, rom[4]);
    do_redirect(32'h34);
    chk("rd_bubble", 32'(instr_valid), 32'd0);
    chk("rd_rom_addr", 32'(rom_addr), 32'd13);
    step();
    chk("rd_tgt_valid", 32'(instr_valid), 32'd1);
    chk("rd_tgt_instr", instr, 32'h0062_8863);
    chk("rd_tgt_pc", instr_pc, 32'h34);
    instr_ready = 1'b1;
    step();
    chk("rd_next_instr", instr, rom[14]);
    chk("rd_next_pc", instr_pc, 32'h38);

    // halt on the end word at 0x78
    do_redirect(32'h74);
    chk("h_bubble", 32'(instr_valid), 32'd0);
    step();
    chk("h_last_instr", instr, 32'h0080_2383);
    chk("h_last_pc", instr_pc, 32'h74);
    chk("h_not_yet", 32'(halted), 32'd0);
    step();
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_valid", 32'(instr_valid), 32'd0);
    chk("h_state", 32'(dbg_state), 32'(ST_HALT));
    repeat (2) step();
    chk("h_hold_valid", 32'(instr_valid), 32'd0);
    chk("h_hold_addr", 32'(rom_addr), 32'd30);
    chk("h_hold_halted", 32'(halted), 32'd1);
    do_redirect(32'h0);
    chk("h_exit_halted", 32'(halted), 32'd0);
    step();
    chk("h_restart_instr", instr, 32'h0030_0413);
    chk("h_restart_valid", 32'(instr_valid), 32'd1);

    // misaligned PC enters ERR; error stays sticky across redirect
    do_redirect(32'h82);
    chk("e_pre_error", 32'(error), 32'd0);
    chk("e_pre_valid", 32'(instr_valid), 32'd0);
    step();
    chk("e_error", 32'(error), 32'd1);
    chk("e_state", 32'(dbg_state), 32'(ST_ERR));
    chk("e_valid", 32'(instr_valid), 32'd0);
    chk("e_count", 32'(dbg_count), 32'd0);
    do_redirect(32'h0);
    chk("e_run_state", 32'(dbg_state), 32'(ST_RUN));
    step();
    chk("e_resume_instr", instr, 32'h0030_0413);
    chk("e_resume_valid", 32'(instr_valid), 32'd1);
    chk("e_sticky", 32'(error), 32'd1);

    // aligned but one past the ROM end
    do_redirect(32'h80);
    step();
    chk("oor_state", 32'(dbg_state), 32'(ST_ERR));
    chk("oor_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    step();
    chk("e_rst_error", 32'(error), 32'd0);
    chk("e_rst_state", 32'(dbg_state), 32'(ST_RUN));

    // reset beats a simultaneous redirect with a full buffer
    reset       = 1'b1;
    instr_ready = 1'b0;
    repeat (2) step();
    chk("rr_full", 32'(dbg_count), 32'd2);
    reset          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h34;
    step();
    chk("rr_valid", 32'(instr_valid), 32'd0);
    chk("rr_count", 32'(dbg_count), 32'd0);
    chk("rr_rom_addr", 32'(rom_addr), 32'd0);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    step();
    chk("rr_first_instr", instr, 32'h0030_0413);
    chk("rr_first_pc", instr_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the single-cycle core's 32-word instruction ROM. It owns the program counter, drives the ROM word address every cycle and captures the combinational ROM read data into a 2-entry prefetch buffer. It presents instructions to decode over a valid/ready handshake and accepts PC redirects from branch/jump resolution. It stops fetching on an all-zero word (end of program) or on an illegal PC.

## Interface
- `ADDR_W`, 5: ROM word-address width; ROM depth = 2^ADDR_W words.
- `RESET_PC`, 32'h0000_0000: byte PC loaded at reset.
- `clk` input 1: clock, rising edge.
- `reset` input 1: reset, synchronous, active-low.
- `rom_addr` output ADDR_W: ROM word address = `pc[ADDR_W+1:2]`.
- `rom_data` input 32: ROM read data, combinational from `rom_addr`.
- `redirect_valid` input 1: load new PC and flush the buffer.
- `redirect_pc` input 32: target byte address.
- `instr_valid` output 1: buffer head valid.
- `instr_ready` input 1: decode accepts head.
- `instr` output 32: head instruction word.
- `instr_pc` output 32: byte PC of head.
- `halted` output 1: fetch stopped on all-zero word.
- `error` output 1: sticky; misaligned or out-of-range PC.

## Operation
- States: RUN, HALT, ERR. Reset → RUN, `pc`=RESET_PC, buffer empty, `halted`=0, `error`=0. All outputs except `rom_addr` read 0 in reset.
- Fetch in RUN when the buffer has space, or is full with a pop this cycle. Fetch pushes {`rom_data`, `pc`} and sets `pc`=`pc`+4 (32-bit wrap, never reached in range).
- Range check before fetch: `pc[31:ADDR_W+2]`≠0 or `pc[1:0]`≠0 → no push, ERR, `error`=1.
- `rom_data`==32'h0 in RUN → no push, `pc` holds, HALT. Buffered entries still drain.
- Pop: `instr_valid && instr_ready`. Push and pop in the same cycle is legal at count 1 or 2; count is unchanged.
- Redirect has top priority. At the edge: flush the buffer, `pc`=`redirect_pc`, state=RUN (also exits HALT/ERR), discard this cycle's fetch and pop. `error` stays set until reset. A misaligned or out-of-range `redirect_pc` re-enters ERR on the next fetch attempt.
- `instr`/`instr_pc` are don't-care when `instr_valid`=0. Once valid, they are held stable until popped or flushed.
- `halted` = (state==HALT).

## Timing
- Reset release at edge E0. Cycle after E0: `rom_addr`=RESET_PC word and the fetch occurs at E1. `instr_valid`=1 from E1, so first-instruction latency is 1 cycle.
- With `instr_ready` held at 1: one instruction per cycle, with no bubbles.
- With `instr_ready`=0: the buffer fills after 2 fetches and `pc` freezes. Throughput resumes the cycle `instr_ready` rises.
- Redirect at edge Er: `instr_valid`=0 in the cycle after Er. The target instruction is valid after Er+1, so redirect penalty is 1 bubble.
- HALT/ERR transitions take effect at the edge of the offending fetch cycle.
- Reset asserted mid-operation overrides everything at that edge, including redirect.

## Structure
- Shared package: state enum {RUN, HALT, ERR}, `END_WORD`=32'h0, buffer depth constant 2, and the fetch entry struct {instr, pc}.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO with push/pop/flush, count, full and empty. It is reused by later pipeline buffering.
- The top level holds the PC register, the state machine, the range check and the redirect mux.

## Test plan
- Reset release, `instr_ready`=1, standard program → `instr` sequence 0x00300413 @0, 0x00100493 @4, 0x01000913 @8, one per cycle.
- `instr_ready`=0 for 5 cycles after reset → `pc`=8, 2 entries held. Head stays 0x00300413 until ready rises, then order is preserved with no loss or duplication.
- Redirect to 0x34 while 2 entries are buffered → one bubble, then `instr`=0x00628863 with `instr_pc`=0x34. The flushed entries never appear.
- Run into word 30 (0x0) at pc 0x78 → the 0x00802383 @0x74 drains, `halted`=1, `instr_valid`=0 thereafter, `rom_addr` holds 30. A redirect to 0 restarts fetch and clears `halted`.
- Redirect to 0x82 → ERR, `error`=1, no push. Then redirect to 0x00 → fetch resumes while `error` stays 1. Reset clears it.
- Assert `reset` with `redirect_valid`=1 and a full buffer → next cycle `pc`=RESET_PC, empty, `instr_valid`=0.
